// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO push arbiter.
//   arb_state_e : arbiter state (idle / packet lock held)
//   rr_next     : round-robin successor, (idx + 1) mod n with explicit wrap
package fifo_arb_pkg;

   typedef enum logic [0:0] {ARB_IDLE, ARB_LOCK} arb_state_e;

   // Explicit wrap so non-power-of-2 counts never rely on natural overflow.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Rotating priority selector: finds the first set request bit at or after a
// start pointer, wrapping past N-1 back to 0.
//   i_req   : request vector
//   i_ptr   : start index for the search
//   o_valid : at least one request is set
//   o_idx   : index of the selected request (0 when none)
module rr_prio_select #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic          o_valid,
   output logic [IW-1:0] o_idx
);

   logic [N-1:0]   w_mask;
   logic [2*N-1:0] w_dbl;
   int             v_pos;

   // Lower half keeps only requests at or above the pointer; the upper half is
   // the full vector, so a plain LSB-first priority encode covers the wrap.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (i >= int'(i_ptr)) w_mask[i] = 1'b1;
      end
      w_dbl = {i_req, i_req & w_mask};
      v_pos = 0;
      for (int i = 2 * int'(N) - 1; i >= 0; i--) begin
         if (w_dbl[i]) v_pos = i;
      end
      o_valid = |i_req;
      o_idx   = (v_pos >= int'(N)) ? IW'(v_pos - int'(N)) : IW'(v_pos);
   end

endmodule

// File: rtl/fifo_rr_push_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO push port between
// NUM_REQ producers. A winner keeps the FIFO until it transfers a beat with
// last set, so packets never interleave. Each beat is tagged with its
// producer index for demultiplexing on the pop side.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   flush_i          : synchronous abort, drops lock and resets pointer
//   req_i/last_i     : per-producer beat valid / end-of-packet
//   data_i           : per-producer payloads, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt_o            : per-producer beat accepted this cycle
//   fifo_push_o      : FIFO push
//   fifo_data_o      : payload to FIFO
//   fifo_idx_o       : producer index to FIFO
//   fifo_full_i      : FIFO full
//   busy_o           : packet lock held
module fifo_rr_push_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ-1:0]            last_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic                          fifo_push_o,
   output logic [DATA_WIDTH-1:0]         fifo_data_o,
   output logic [IDX_WIDTH-1:0]          fifo_idx_o,
   input  logic                          fifo_full_i,
   output logic                          busy_o
);

   arb_state_e           r_state;
   logic [IDX_WIDTH-1:0] r_ptr;
   logic [IDX_WIDTH-1:0] r_owner;

   logic                 w_rr_valid;
   logic [IDX_WIDTH-1:0] w_rr_idx;
   logic [IDX_WIDTH-1:0] w_sel;
   logic [IDX_WIDTH-1:0] w_sel_next;
   logic                 w_valid;
   logic                 w_fire;
   logic                 w_locked;

   rr_prio_select #(
      .N  (NUM_REQ),
      .IW (IDX_WIDTH)
   ) u_rr_prio_select (
      .i_req   (req_i),
      .i_ptr   (r_ptr),
      .o_valid (w_rr_valid),
      .o_idx   (w_rr_idx)
   );

   // While locked only the owner is considered; everyone else is ignored.
   always_comb begin
      w_locked   = (r_state == ARB_LOCK);
      w_sel      = w_locked ? r_owner : w_rr_idx;
      w_valid    = w_locked ? req_i[r_owner] : w_rr_valid;
      w_fire     = w_valid & ~fifo_full_i & ~flush_i;
      w_sel_next = IDX_WIDTH'(rr_next(32'(w_sel), NUM_REQ));
   end

   always_comb begin
      gnt_o       = '0;
      fifo_data_o = '0;
      fifo_idx_o  = '0;
      fifo_push_o = w_fire;
      if (w_fire) begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            gnt_o[i] = (w_sel == IDX_WIDTH'(i));
         end
         fifo_data_o = data_i[32'(w_sel) * DATA_WIDTH +: DATA_WIDTH];
         fifo_idx_o  = w_sel;
      end
   end

   assign busy_o = w_locked;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ARB_IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
      end else if (flush_i) begin
         r_state <= ARB_IDLE;
         r_ptr   <= '0;
      end else if (w_fire) begin
         if (last_i[w_sel]) begin
            // Packet complete: release and rotate past the finishing producer.
            r_state <= ARB_IDLE;
            r_ptr   <= w_sel_next;
         end else begin
            r_state <= ARB_LOCK;
            r_owner <= w_sel;
         end
      end
   end

`ifndef SYNTHESIS
   logic [NUM_REQ-1:0] w_owner_oh;
   always_comb begin
      w_owner_oh = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         w_owner_oh[i] = (r_owner == IDX_WIDTH'(i));
      end
   end

   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert ($onehot0(gnt_o)) else $error("gnt_o not onehot0: %b", gnt_o);
         assert (!(fifo_push_o && fifo_full_i)) else $error("push while FIFO full");
         assert (!(w_locked && |(gnt_o & ~w_owner_oh)))
            else $error("grant to non-owner while locked: %b", gnt_o);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rr_push_arbiter.sv
module tb_fifo_rr_push_arbiter;

   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Four-producer instance
   logic          rst4, flush4, full4, push4, busy4;
   logic [3:0]    req4, last4, gnt4;
   logic [4*DW-1:0] data4;
   logic [DW-1:0] fd4;
   logic [1:0]    idx4;

   // Three-producer instance (non-power-of-2 wrap)
   logic          rst3, flush3, full3, push3, busy3;
   logic [2:0]    req3, last3, gnt3;
   logic [3*DW-1:0] data3;
   logic [DW-1:0] fd3;
   logic [1:0]    idx3;

   int checks   = 0;
   int failures = 0;

   fifo_rr_push_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW)) dut4 (
      .clk_i       (clk),
      .rst_i       (rst4),
      .flush_i     (flush4),
      .req_i       (req4),
      .last_i      (last4),
      .data_i      (data4),
      .gnt_o       (gnt4),
      .fifo_push_o (push4),
      .fifo_data_o (fd4),
      .fifo_idx_o  (idx4),
      .fifo_full_i (full4),
      .busy_o      (busy4)
   );

   fifo_rr_push_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW)) dut3 (
      .clk_i       (clk),
      .rst_i       (rst3),
      .flush_i     (flush3),
      .req_i       (req3),
      .last_i      (last3),
      .data_i      (data3),
      .gnt_o       (gnt3),
      .fifo_push_o (push3),
      .fifo_data_o (fd3),
      .fifo_idx_o  (idx3),
      .fifo_full_i (full3),
      .busy_o      (busy3)
   );

   typedef struct {
      string      nm;
      logic [3:0] req;
      logic [3:0] last;
      bit         full;
      bit         flush;
      logic [3:0] gnt;
      bit         busy;
   } vec_t;

   // Reference: packet lock flag, owner, rotating start index.
   typedef struct {
      bit locked;
      int owner;
      int ptr;
   } model_t;

   function automatic vec_t mk(input string nm, input logic [3:0] req, input logic [3:0] last,
                               input bit full, input bit flush, input logic [3:0] gnt,
                               input bit busy);
      vec_t v;
      v.nm = nm; v.req = req; v.last = last; v.full = full; v.flush = flush;
      v.gnt = gnt; v.busy = busy;
      return v;
   endfunction

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input int w, input logic [3:0] rq, input logic [3:0] lst, input bit fl,
                        input bit fs, input logic [127:0] d);
      if (w == 4) begin
         req4 = rq; last4 = lst; full4 = fl; flush4 = fs; data4 = d;
      end else begin
         req3 = rq[2:0]; last3 = lst[2:0]; full3 = fl; flush3 = fs; data3 = d[95:0];
      end
   endtask

   task automatic sample(input int w, output logic [3:0] g, output logic p,
                         output logic [1:0] ix, output logic [DW-1:0] fd, output logic b);
      if (w == 4) begin
         g = gnt4; p = push4; ix = idx4; fd = fd4; b = busy4;
      end else begin
         g = {1'b0, gnt3}; p = push3; ix = idx3; fd = fd3; b = busy3;
      end
   endtask

   task automatic check_all(input string nm, input int w, input logic [127:0] d,
                            input logic [3:0] eg, input bit eb);
      logic [3:0] g; logic p; logic [1:0] ix; logic [DW-1:0] fd; logic b;
      int ei;
      logic [DW-1:0] ed;
      ei = 0;
      for (int k = 0; k < 4; k++) if (eg[k]) ei = k;
      ed = (eg != 0) ? d[ei*DW +: DW] : '0;
      sample(w, g, p, ix, fd, b);
      cmp({nm, ".gnt"},  64'(g),  64'(eg));
      cmp({nm, ".push"}, 64'(p),  64'(eg != 0));
      cmp({nm, ".idx"},  64'(ix), 64'(ei));
      cmp({nm, ".data"}, 64'(fd), 64'(ed));
      cmp({nm, ".busy"}, 64'(b),  64'(eb));
   endtask

   task automatic step(input int w, input vec_t v);
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      drive(w, v.req, v.last, v.full, v.flush, d);
      @(negedge clk);
      check_all(v.nm, w, d, v.gnt, v.busy);
      @(posedge clk);
      #1;
   endtask

   function automatic void mdl_eval(input model_t s, input int n, input logic [3:0] req,
                                    input bit full, input bit flush,
                                    output int sel, output bit fire);
      bit valid;
      valid = 1'b0;
      sel   = 0;
      if (s.locked) begin
         sel   = s.owner;
         valid = req[s.owner];
      end else begin
         for (int k = 0; k < n; k++) begin
            int j;
            j = (s.ptr + k) % n;
            if (req[j] && !valid) begin
               valid = 1'b1;
               sel   = j;
            end
         end
      end
      fire = valid && !full && !flush;
   endfunction

   function automatic model_t mdl_next(input model_t s, input int n, input logic [3:0] last,
                                       input bit flush, input bit fire, input int sel);
      model_t r;
      r = s;
      if (flush) begin
         r.locked = 1'b0;
         r.ptr    = 0;
      end else if (fire) begin
         if (last[sel]) begin
            r.locked = 1'b0;
            r.ptr    = (sel + 1) % n;
         end else begin
            r.locked = 1'b1;
            r.owner  = sel;
         end
      end
      return r;
   endfunction

   task automatic pulse_reset(input int w);
      if (w == 4) rst4 = 1'b1; else rst3 = 1'b1;
      #2;
      if (w == 4) rst4 = 1'b0; else rst3 = 1'b0;
   endtask

   task automatic rnd(input int w, input int n, input int cycles);
      model_t m;
      logic [3:0] rq, lst, eg;
      logic [127:0] d;
      bit fl, fs, fire;
      int sel;
      drive(w, 4'b0, 4'b0, 1'b0, 1'b0, '0);
      pulse_reset(w);
      m = '{locked: 1'b0, owner: 0, ptr: 0};
      for (int c = 0; c < cycles; c++) begin
         rq  = 4'($urandom) & 4'((1 << n) - 1);
         lst = 4'($urandom) & 4'((1 << n) - 1);
         fl  = ($urandom_range(3) == 0);
         fs  = ($urandom_range(31) == 0);
         d   = {$urandom, $urandom, $urandom, $urandom};
         drive(w, rq, lst, fl, fs, d);
         mdl_eval(m, n, rq, fl, fs, sel, fire);
         eg = fire ? 4'(1 << sel) : 4'b0;
         @(negedge clk);
         check_all($sformatf("rnd%0d[%0d]", n, c), w, d, eg, m.locked);
         m = mdl_next(m, n, lst, fs, fire, sel);
         @(posedge clk);
         #1;
      end
   endtask

   vec_t vecs4[$];
   vec_t vecs3a[$];
   vec_t vecs3b[$];

   initial begin
      // Plan 1: alternating single-beat packets
      for (int i = 0; i < 2; i++) begin
         vecs4.push_back(mk("p1_rr", 4'b1010, 4'b1111, 0, 0, 4'b0010, 0));
         vecs4.push_back(mk("p1_rr", 4'b1010, 4'b1111, 0, 0, 4'b1000, 0));
      end
      // Plan 2: three-beat packet from producer 0 blocks producer 1
      vecs4.push_back(mk("p2_b1",  4'b0011, 4'b0010, 0, 0, 4'b0001, 0));
      vecs4.push_back(mk("p2_b2",  4'b0011, 4'b0010, 0, 0, 4'b0001, 1));
      vecs4.push_back(mk("p2_b3",  4'b0011, 4'b0011, 0, 0, 4'b0001, 1));
      vecs4.push_back(mk("p2_nxt", 4'b0011, 4'b0011, 0, 0, 4'b0010, 0));
      // Plan 3: FIFO full while producer 2 holds the lock
      vecs4.push_back(mk("p3_lock", 4'b0100, 4'b0000, 0, 0, 4'b0100, 0));
      for (int i = 0; i < 5; i++)
         vecs4.push_back(mk("p3_full", 4'b1111, 4'b0000, 1, 0, 4'b0000, 1));
      vecs4.push_back(mk("p3_rel", 4'b1111, 4'b0100, 0, 0, 4'b0100, 1));
      // Plan 4: owner 0 bubbles while producer 3 waits
      vecs4.push_back(mk("p4_lock", 4'b0001, 4'b0000, 0, 0, 4'b0001, 0));
      for (int i = 0; i < 3; i++)
         vecs4.push_back(mk("p4_bub", 4'b1000, 4'b1000, 0, 0, 4'b0000, 1));
      vecs4.push_back(mk("p4_last", 4'b1001, 4'b1001, 0, 0, 4'b0001, 1));
      vecs4.push_back(mk("p4_p3",   4'b1000, 4'b1000, 0, 0, 4'b1000, 0));
      // Plan 5: flush mid-packet, pointer back to 0
      vecs4.push_back(mk("p5_pre",  4'b0100, 4'b0100, 0, 0, 4'b0100, 0));
      vecs4.push_back(mk("p5_lock", 4'b0010, 4'b0000, 0, 0, 4'b0010, 0));
      vecs4.push_back(mk("p5_flsh", 4'b1111, 4'b0000, 0, 1, 4'b0000, 1));
      vecs4.push_back(mk("p5_win0", 4'b1111, 4'b1111, 0, 0, 4'b0001, 0));
      // Full while idle: no grant, pointer unchanged
      vecs4.push_back(mk("idle_full", 4'b1111, 4'b1111, 1, 0, 4'b0000, 0));
      vecs4.push_back(mk("idle_go",   4'b1111, 4'b1111, 0, 0, 4'b0010, 0));

      // Plan 6 (3 producers): lock then async reset; then wrap checks
      vecs3a.push_back(mk("p6_lock", 4'b0001, 4'b0000, 0, 0, 4'b0001, 0));
      vecs3b.push_back(mk("p6_w2",   4'b0100, 4'b0100, 0, 0, 4'b0100, 0));
      vecs3b.push_back(mk("p6_w0",   4'b0111, 4'b0111, 0, 0, 4'b0001, 0));
      vecs3b.push_back(mk("p6_l2",   4'b0100, 4'b0000, 0, 0, 4'b0100, 0));
      vecs3b.push_back(mk("p6_e2",   4'b0111, 4'b0100, 0, 0, 4'b0100, 1));
      vecs3b.push_back(mk("p6_wrap", 4'b0111, 4'b0111, 0, 0, 4'b0001, 0));

      rst4 = 1'b1; rst3 = 1'b1;
      drive(4, 4'b0, 4'b0, 1'b0, 1'b0, '0);
      drive(3, 4'b0, 4'b0, 1'b0, 1'b0, '0);
      #2;
      check_all("in_reset4", 4, '0, 4'b0, 0);
      check_all("in_reset3", 3, '0, 4'b0, 0);
      @(posedge clk);
      #1;
      rst4 = 1'b0; rst3 = 1'b0;
      @(negedge clk);
      check_all("post_reset4", 4, '0, 4'b0, 0);
      @(posedge clk);
      #1;

      foreach (vecs4[i]) step(4, vecs4[i]);

      foreach (vecs3a[i]) step(3, vecs3a[i]);
      cmp("p6_busy_before_rst", 64'(busy3), 64'd1);
      rst3 = 1'b1;
      #1;
      cmp("p6_busy_async_rst", 64'(busy3), 64'd0);
      #1;
      rst3 = 1'b0;
      foreach (vecs3b[i]) step(3, vecs3b[i]);

      rnd(4, 4, 400);
      rnd(3, 3, 400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
